dm_bus_arbiter: RTL and testbench

DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

---
 rtl/dm_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter (M0 = core, M1 = loader/debug) in front of a single-port data memory.
// Optional write-watch comparator is built only when DM_ARB_WATCH_EN is defined.
module dm_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] A_dm,
    output logic [DW-1:0] write_data_dm,
    output logic          we_dm,
    output logic          re_dm,
    input  logic [DW-1:0] read_data_dm,
    input  logic [AW-1:0] watch_addr,
    input  logic [DW-1:0] watch_data,
    output logic          watch_hit
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    logic [1:0]    state_reg, state_next;
    logic          last_reg, last_next;
    logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
    logic [1:0]    rvalid_reg;

    logic [1:0]    req, we, lock, gnt;
    logic [DW-1:0] rdata [2];
    logic          cur, oth;

    assign req  = {m1_req, m0_req};
    assign we   = {m1_we, m0_we};
    assign lock = {m1_lock, m0_lock};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic [1:0] OWN_STATE = (gi == 0) ? OWN0 : OWN1;
            assign gnt[gi]   = (state_reg == OWN_STATE) & req[gi];
            assign rdata[gi] = rvalid_reg[gi] ? read_data_dm : '0;
        end
    endgenerate

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_reg[0];
    assign m1_rvalid = rvalid_reg[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];

    // Memory port is driven only by the granted master; idle bus is all zero.
    always_comb begin
        A_dm          = '0;
        write_data_dm = '0;
        we_dm         = 1'b0;
        re_dm         = 1'b0;
        if (gnt[0]) begin
            A_dm          = m0_addr;
            write_data_dm = m0_wdata;
            we_dm         = m0_we;
            re_dm         = ~m0_we;
        end else if (gnt[1]) begin
            A_dm          = m1_addr;
            write_data_dm = m1_wdata;
            we_dm         = m1_we;
            re_dm         = ~m1_we;
        end
    end

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        last_next      = last_reg;
        cur            = (state_reg == OWN1);
        oth            = ~cur;
        if (gnt[0]) begin
            last_next = 1'b0;
        end else if (gnt[1]) begin
            last_next = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                burst_cnt_next = '0;
                // On contention the master that was not served last wins.
                if (req[0] && (!req[1] || last_reg)) begin
                    state_next = OWN0;
                end else if (req[1]) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (req[cur] && lock[cur] && (burst_cnt_reg < BURST_LAST)) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end else begin
                    burst_cnt_next = '0;
                    if (req[oth]) begin
                        state_next = oth ? OWN1 : OWN0;
                    end else if (!(req[cur] && lock[cur])) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            burst_cnt_reg <= '0;
            rvalid_reg    <= 2'b00;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            rvalid_reg    <= gnt & ~we;
        end
    end

`ifdef DM_ARB_WATCH_EN
    logic watch_hit_reg;

    // we_dm is only ever high on a granted write, so it qualifies the match alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            watch_hit_reg <= 1'b0;
        end else begin
            watch_hit_reg <= we_dm & (A_dm == watch_addr) & (write_data_dm == watch_data);
        end
    end

    assign watch_hit = watch_hit_reg;
`else
    logic unused_watch;
    assign unused_watch = ^{watch_addr, watch_data};
    assign watch_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter: a rule-level model predicts accesses, read returns
// and watch pulses; an independent monitor pops and compares them as the DUT produces them.
module tb_dm_bus_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] A_dm;
    logic [DW-1:0] write_data_dm;
    logic          we_dm, re_dm;
    logic [DW-1:0] read_data_dm;
    logic [AW-1:0] watch_addr;
    logic [DW-1:0] watch_data;
    logic          watch_hit;

    dm_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .A_dm(A_dm), .write_data_dm(write_data_dm), .we_dm(we_dm), .re_dm(re_dm),
        .read_data_dm(read_data_dm), .watch_addr(watch_addr), .watch_data(watch_data),
        .watch_hit(watch_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: registered read, one word per low address.
    logic          env_clr;
    logic [DW-1:0] env_mem [64];

    function automatic logic [DW-1:0] seed_val(input int i);
        return 32'hC0DE_0000 | DW'(i * 257);
    endfunction

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= seed_val(i);
        end else begin
            if (we_dm) env_mem[A_dm[5:0]] <= write_data_dm;
            if (re_dm) read_data_dm <= env_mem[A_dm[5:0]];
        end
    end

    typedef struct {
        int            cyc;
        int            m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            cyc;
        int            m;
        logic [DW-1:0] data;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   w_q[$];

    int tests = 0;
    int fails = 0;
    logic mon_en    = 1'b0;
    logic burst_win = 1'b0;
    int   burst_max = 0;

    task automatic chk(input string name, input bit ok, input string got, input string exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %s, expected %s", name, cyc, got, exp);
        end
    endtask

    // Reference model: owner (-1 = nobody), length of current locked run, last served master.
    int            own    = -1;
    int            run    = 0;
    int            last_m = 1;
    logic [DW-1:0] mem_model [64];

    task automatic model_eval();
        logic          rq [2];
        logic          lk [2];
        logic          wv [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int            g;
        int            o;
        rq[0] = m0_req;   rq[1] = m1_req;
        lk[0] = m0_lock;  lk[1] = m1_lock;
        wv[0] = m0_we;    wv[1] = m1_we;
        ad[0] = m0_addr;  ad[1] = m1_addr;
        wd[0] = m0_wdata; wd[1] = m1_wdata;
        g = -1;
        if (own >= 0 && rq[own]) g = own;
        if (g >= 0) begin
            acc_q.push_back('{cyc: cyc, m: g, we: wv[g], addr: ad[g], data: wd[g]});
            last_m = g;
            if (wv[g]) begin
                mem_model[ad[g][5:0]] = wd[g];
`ifdef DM_ARB_WATCH_EN
                if (!rst && ad[g] == watch_addr && wd[g] == watch_data) w_q.push_back(cyc + 1);
`endif
            end else if (!rst) begin
                rd_q.push_back('{cyc: cyc + 1, m: g, data: mem_model[ad[g][5:0]]});
            end
        end
        if (own < 0) begin
            if (rq[0] && rq[1]) own = 1 - last_m;
            else if (rq[0])     own = 0;
            else if (rq[1])     own = 1;
            run = 0;
        end else begin
            o = 1 - own;
            if (rq[own] && lk[own] && run < MAX_BURST - 1) begin
                run++;
            end else begin
                run = 0;
                if (rq[o])                       own = o;
                else if (!(rq[own] && lk[own]))  own = -1;
            end
        end
        if (rst) begin
            own = -1; run = 0; last_m = 1;
        end
    endtask

    task automatic cycle_end();
        model_eval();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic q, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = q; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic q, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = q; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor
    initial begin
        acc_t e;
        rd_t  r;
        int   wc;
        int   g;
        int   run1;
        run1 = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            #2;
            if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                e = acc_q.pop_front();
                chk("missing_grant", 1'b0, "no grant", $sformatf("m%0d at cyc %0d", e.m, e.cyc));
            end
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                r = rd_q.pop_front();
                chk("missing_rvalid", 1'b0, "no rvalid", $sformatf("m%0d at cyc %0d", r.m, r.cyc));
            end
            if (w_q.size() > 0 && w_q[0] < cyc) begin
                wc = w_q.pop_front();
                chk("missing_watch", 1'b0, "no watch_hit", $sformatf("pulse at cyc %0d", wc));
            end

            chk("gnt_onehot", !(m0_gnt && m1_gnt), $sformatf("%b%b", m1_gnt, m0_gnt), "not both");
            if (m0_gnt || m1_gnt) begin
                g = m1_gnt ? 1 : 0;
                $display("[TB] cyc %0d m%0d %s addr=0x%0h wdata=0x%0h", cyc, g,
                         we_dm ? "wr" : "rd", A_dm, write_data_dm);
                if (acc_q.size() == 0) begin
                    chk("unexpected_grant", 1'b0, $sformatf("m%0d", g), "no grant");
                end else begin
                    e = acc_q.pop_front();
                    chk("grant", e.cyc == cyc && e.m == g && A_dm == e.addr && we_dm == e.we &&
                        re_dm == !e.we && write_data_dm == e.data,
                        $sformatf("m%0d we=%b re=%b a=%0h d=%0h", g, we_dm, re_dm, A_dm, write_data_dm),
                        $sformatf("m%0d we=%b re=%b a=%0h d=%0h cyc %0d", e.m, e.we, !e.we,
                                  e.addr, e.data, e.cyc));
                end
            end else begin
                chk("idle_bus", A_dm == '0 && write_data_dm == '0 && !we_dm && !re_dm,
                    $sformatf("a=%0h d=%0h we=%b re=%b", A_dm, write_data_dm, we_dm, re_dm),
                    "all zero");
            end

            chk("rvalid_onehot", !(m0_rvalid && m1_rvalid), $sformatf("%b%b", m1_rvalid, m0_rvalid),
                "not both");
            if (m0_rvalid || m1_rvalid) begin
                g = m1_rvalid ? 1 : 0;
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", 1'b0, $sformatf("m%0d", g), "no rvalid");
                end else begin
                    r = rd_q.pop_front();
                    chk("rdata", r.cyc == cyc && r.m == g &&
                        (g == 0 ? (m0_rdata == r.data && m1_rdata == '0)
                                : (m1_rdata == r.data && m0_rdata == '0)),
                        $sformatf("m%0d d0=%0h d1=%0h", g, m0_rdata, m1_rdata),
                        $sformatf("m%0d data=%0h cyc %0d", r.m, r.data, r.cyc));
                end
            end else begin
                chk("rdata_idle", m0_rdata == '0 && m1_rdata == '0,
                    $sformatf("d0=%0h d1=%0h", m0_rdata, m1_rdata), "zero");
            end

            if (watch_hit) begin
                if (w_q.size() == 0) begin
                    chk("unexpected_watch", 1'b0, "watch_hit=1", "0");
                end else begin
                    wc = w_q.pop_front();
                    chk("watch_hit", wc == cyc, $sformatf("cyc %0d", cyc), $sformatf("cyc %0d", wc));
                end
            end

            if (burst_win && m1_gnt) run1++;
            else run1 = 0;
            if (run1 > burst_max) burst_max = run1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        env_clr    = 1'b1;
        watch_addr = 32'h4;
        watch_data = 32'h7;
        idle_all();
        for (int i = 0; i < 64; i++) mem_model[i] = seed_val(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        env_clr = 1'b0;
        #1;
        chk("rst_m0_gnt", m0_gnt == 1'b0, $sformatf("%b", m0_gnt), "0");
        chk("rst_m1_gnt", m1_gnt == 1'b0, $sformatf("%b", m1_gnt), "0");
        chk("rst_we_dm", we_dm == 1'b0, $sformatf("%b", we_dm), "0");
        chk("rst_re_dm", re_dm == 1'b0, $sformatf("%b", re_dm), "0");
        chk("rst_m0_rvalid", m0_rvalid == 1'b0, $sformatf("%b", m0_rvalid), "0");
        chk("rst_m1_rvalid", m1_rvalid == 1'b0, $sformatf("%b", m1_rvalid), "0");
        chk("rst_watch_hit", watch_hit == 1'b0, $sformatf("%b", watch_hit), "0");
        mon_en = 1'b1;
        cycle_end();

        // Lone M0 read at 0x10: grant next cycle, data the cycle after.
        set_m0(1'b1, 1'b0, 1'b0, 32'h10, '0);
        cycle_end();
        cycle_end();
        idle_all();
        repeat (2) cycle_end();

        // Both masters reading unlocked: strict alternation.
        for (int i = 0; i < 10; i++) begin
            set_m0(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), $urandom);
            set_m1(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), $urandom);
            cycle_end();
        end
        idle_all();
        repeat (2) cycle_end();

        // M1 locked writes against a waiting M0: run limited to MAX_BURST.
        burst_win = 1'b1;
        for (int i = 0; i < 22; i++) begin
            set_m0(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), $urandom);
            set_m1(1'b1, 1'b1, 1'b1, AW'($urandom_range(0, 63)), $urandom);
            cycle_end();
        end
        burst_win = 1'b0;
        idle_all();
        repeat (3) cycle_end();

        // Reset lands on the M0 read grant cycle.
        set_m0(1'b1, 1'b0, 1'b0, 32'h10, '0);
        cycle_end();
        rst = 1'b1;
        cycle_end();
        rst = 1'b0;
        idle_all();
        repeat (3) cycle_end();

        // Write-watch hit, then a near miss on data.
        set_m0(1'b1, 1'b1, 1'b0, 32'h4, 32'h7);
        repeat (2) cycle_end();
        idle_all();
        repeat (3) cycle_end();
        set_m0(1'b1, 1'b1, 1'b0, 32'h4, 32'h6);
        repeat (2) cycle_end();
        idle_all();
        repeat (3) cycle_end();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_m0($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                   AW'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : $urandom);
            set_m1($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 1) == 0,
                   AW'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : $urandom);
            cycle_end();
        end
        rst = 1'b0;
        idle_all();
        repeat (6) cycle_end();

        chk("burst_len", burst_max == MAX_BURST, $sformatf("%0d", burst_max), $sformatf("%0d", MAX_BURST));
        chk("acc_q_drained", acc_q.size() == 0, $sformatf("%0d left", acc_q.size()), "0 left");
        chk("rd_q_drained", rd_q.size() == 0, $sformatf("%0d left", rd_q.size()), "0 left");
        chk("watch_q_drained", w_q.size() == 0, $sformatf("%0d left", w_q.size()), "0 left");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
